// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample/checksum widths and the coefficient-loader state type.
package fir_pkg;

    localparam int IN_SAMPLE_WIDTH = 16;
    localparam int CHECKSUM_WIDTH  = 16;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} coef_load_state_t;

endpackage

// File: rtl/fir_coef_sum.sv
// Combinational adder over all 16-bit lanes of one coefficient word, reduced mod 2^16.
module fir_coef_sum
    import fir_pkg::*;
#(
    parameter int SAMPLES_NUM = 8
) (
    input  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0] i_lanes,
    output logic [CHECKSUM_WIDTH-1:0]              o_sum
);

    // Full-precision accumulator so no lane carry is lost before the final truncation.
    localparam int SUM_W = IN_SAMPLE_WIDTH + $clog2(SAMPLES_NUM);

    logic [SUM_W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int unsigned i = 0; i < SAMPLES_NUM; i++) begin
            w_acc = w_acc + SUM_W'(i_lanes[i*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH]);
        end
        o_sum = w_acc[CHECKSUM_WIDTH-1:0];
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient-load stage: sequential memory write port during a load window,
// then commits word count, checksum and overflow flag when the window closes.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter  int SAMPLES_NUM = 8,
    parameter  int WORDS_NUM   = 8192,
    localparam int ADDR_W      = $clog2(WORDS_NUM)
) (
    input  logic                                clkIn,
    input  logic                                resetIn,
    input  logic                                firLoadIn,
    input  logic                                firWriteIn,
    input  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firIn,
    output logic                                memWeOut,
    output logic [ADDR_W-1:0]                   memAddrOut,
    output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0] memDataOut,
    output logic [ADDR_W:0]                     tapWordsOut,
    output logic [CHECKSUM_WIDTH-1:0]           checksumOut,
    output logic                                overflowOut,
    output logic                                loadDoneOut,
    output logic                                busyOut
);

    localparam int             DATA_W  = IN_SAMPLE_WIDTH * SAMPLES_NUM;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(WORDS_NUM);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    coef_load_state_t          r_state;
    logic [ADDR_W:0]           r_cnt;
    logic [CHECKSUM_WIDTH-1:0] r_sum;
    logic                      r_ovf_pend;
    logic                      r_we;
    logic [ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]         r_data;
    logic [ADDR_W:0]           r_tap;
    logic [CHECKSUM_WIDTH-1:0] r_chk;
    logic                      r_ovf;
    logic                      r_done;
    logic                      r_busy;
    logic [CHECKSUM_WIDTH-1:0] w_lane_sum;

    fir_coef_sum #(
        .SAMPLES_NUM (SAMPLES_NUM)
    ) u_sum (
        .i_lanes (firIn),
        .o_sum   (w_lane_sum)
    );

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_ovf_pend <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tap      <= '0;
            r_chk      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (firLoadIn) begin
                        r_state    <= LOAD;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_ovf_pend <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    // A strobe on the closing cycle is still accepted and lands in the commit.
                    if (firWriteIn) begin
                        if (r_cnt < CNT_MAX) begin
                            r_we   <= 1'b1;
                            r_addr <= r_cnt[ADDR_W-1:0];
                            r_data <= firIn;
                            r_cnt  <= r_cnt + CNT_ONE;
                            r_sum  <= r_sum + w_lane_sum;
                        end else begin
                            r_ovf_pend <= 1'b1;
                        end
                    end
                    if (!firLoadIn) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_tap   <= r_cnt;
                    r_chk   <= r_sum;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign memWeOut    = r_we;
    assign memAddrOut  = r_addr;
    assign memDataOut  = r_data;
    assign tapWordsOut = r_tap;
    assign checksumOut = r_chk;
    assign overflowOut = r_ovf;
    assign loadDoneOut = r_done;
    assign busyOut     = r_busy;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader: a full-depth and a 4-word instance share stimulus
// and are checked against a window-level model of accepted words, writes and commits.
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int SN = 8;
    localparam int WB = 8192;
    localparam int WS = 4;
    localparam int DW = 16 * SN;
    localparam int AB = $clog2(WB);
    localparam int AS = $clog2(WS);

    logic          clk;
    logic          rst;
    logic          load;
    logic          wr;
    logic [DW-1:0] din;

    logic          b_we, b_ovf, b_done, b_busy;
    logic [AB-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [AB:0]   b_tap;
    logic [15:0]   b_chk;

    logic          s_we, s_ovf, s_done, s_busy;
    logic [AS-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [AS:0]   s_tap;
    logic [15:0]   s_chk;

    fir_coef_loader #(.SAMPLES_NUM(SN), .WORDS_NUM(WB)) u_big (
        .clkIn(clk), .resetIn(rst), .firLoadIn(load), .firWriteIn(wr), .firIn(din),
        .memWeOut(b_we), .memAddrOut(b_addr), .memDataOut(b_data),
        .tapWordsOut(b_tap), .checksumOut(b_chk), .overflowOut(b_ovf),
        .loadDoneOut(b_done), .busyOut(b_busy)
    );

    fir_coef_loader #(.SAMPLES_NUM(SN), .WORDS_NUM(WS)) u_small (
        .clkIn(clk), .resetIn(rst), .firLoadIn(load), .firWriteIn(wr), .firIn(din),
        .memWeOut(s_we), .memAddrOut(s_addr), .memDataOut(s_data),
        .tapWordsOut(s_tap), .checksumOut(s_chk), .overflowOut(s_ovf),
        .loadDoneOut(s_done), .busyOut(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t bq[$];
    wr_t sq[$];
    int  b_done_n;
    int  s_done_n;

    always @(negedge clk) begin
        if (b_we)   bq.push_back('{16'(b_addr), b_data});
        if (s_we)   sq.push_back('{16'(s_addr), s_data});
        if (b_done) b_done_n++;
        if (s_done) s_done_n++;
    end

    int errs;
    int checks;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Window-level model state: the words presented and what each instance last committed.
    logic [DW-1:0] win[$];
    int            pb_tap, ps_tap;
    logic [15:0]   pb_chk, ps_chk;
    logic          pb_ovf, ps_ovf;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < SN; i++) w[i*16 +: 16] = 16'($urandom);
        return w;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        return {SN{v}};
    endfunction

    function automatic logic [15:0] word_sum(input logic [DW-1:0] w);
        int unsigned s = 0;
        for (int i = 0; i < SN; i++) s += w[i*16 +: 16];
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        win.delete();
        for (int i = 0; i < n; i++) win.push_back(rand_word());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_b_we"}, b_we, 0);     chk({tag, "_s_we"}, s_we, 0);
        chk({tag, "_b_addr"}, b_addr, 0); chk({tag, "_s_addr"}, s_addr, 0);
        chk({tag, "_b_data"}, b_data, 0); chk({tag, "_s_data"}, s_data, 0);
        chk({tag, "_b_tap"}, b_tap, 0);   chk({tag, "_s_tap"}, s_tap, 0);
        chk({tag, "_b_chk"}, b_chk, 0);   chk({tag, "_s_chk"}, s_chk, 0);
        chk({tag, "_b_ovf"}, b_ovf, 0);   chk({tag, "_s_ovf"}, s_ovf, 0);
        chk({tag, "_b_done"}, b_done, 0); chk({tag, "_s_done"}, s_done, 0);
        chk({tag, "_b_busy"}, b_busy, 0); chk({tag, "_s_busy"}, s_busy, 0);
    endtask

    task automatic check_side(input string tag, input int cap, input int tap_act,
                              input logic [15:0] chk_act, input logic ovf_act,
                              input int done_n, input int addr_act, input logic [DW-1:0] data_act,
                              input bit big, output int k, output logic [15:0] sum);
        int n;
        n   = win.size();
        k   = (n < cap) ? n : cap;
        sum = '0;
        for (int i = 0; i < k; i++) sum += word_sum(win[i]);
        chk({tag, "_tap"}, tap_act, k);
        chk({tag, "_chk"}, chk_act, sum);
        chk({tag, "_ovf"}, ovf_act, (n > cap) ? 1 : 0);
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_nwrites"}, big ? bq.size() : sq.size(), k);
        for (int i = 0; i < k && i < (big ? bq.size() : sq.size()); i++) begin
            wr_t e;
            e = big ? bq[i] : sq[i];
            chk({tag, "_waddr"}, e.addr, i);
            chk({tag, "_wdata"}, e.data, win[i]);
        end
        if (k > 0) begin
            chk({tag, "_addr_hold"}, addr_act, k - 1);
            chk({tag, "_data_hold"}, data_act, win[k-1]);
        end
    endtask

    task automatic run_window(input string tag, input bit coincide, input bit gaps, input bit idle_wr);
        int          n, kb, ks;
        logic [15:0] sb, ss;
        n = win.size();
        bq.delete(); sq.delete();
        b_done_n = 0; s_done_n = 0;

        // Opening cycle: any strobe here is seen in IDLE and must be dropped.
        load = 1'b1; wr = idle_wr; din = rand_word();
        tick();
        chk({tag, "_busy_load"}, {b_busy, s_busy}, 2'b11);

        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr = 1'b0; din = rand_word();
                tick();
            end
            wr = 1'b1; din = win[i];
            if (coincide && i == n - 1) load = 1'b0;
            tick();
            if (i == 0) begin
                chk({tag, "_b_hold_tap"}, b_tap, pb_tap);
                chk({tag, "_s_hold_tap"}, s_tap, ps_tap);
                chk({tag, "_b_hold_chk"}, b_chk, pb_chk);
                chk({tag, "_s_hold_ovf"}, s_ovf, ps_ovf);
            end
        end
        if (n == 0 || !coincide) begin
            load = 1'b0; wr = 1'b0;
            tick();
        end

        chk({tag, "_busy_commit"}, {b_busy, s_busy}, 2'b11);
        chk({tag, "_b_pre_tap"}, b_tap, pb_tap);
        chk({tag, "_s_pre_ovf"}, s_ovf, ps_ovf);
        wr = 1'($urandom_range(0, 1)); din = rand_word();
        tick();
        chk({tag, "_done_pulse"}, {b_done, s_done}, 2'b11);

        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; din = rand_word();
            tick();
        end
        wr = 1'b0;
        tick();

        check_side({tag, "_b"}, WB, int'(b_tap), b_chk, b_ovf, b_done_n, int'(b_addr), b_data, 1'b1, kb, sb);
        check_side({tag, "_s"}, WS, int'(s_tap), s_chk, s_ovf, s_done_n, int'(s_addr), s_data, 1'b0, ks, ss);
        chk({tag, "_busy_idle"}, {b_busy, s_busy}, 2'b00);
        pb_tap = kb; pb_chk = sb; pb_ovf = (n > WB);
        ps_tap = ks; ps_chk = ss; ps_ovf = (n > WS);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        errs = 0; checks = 0;
        b_done_n = 0; s_done_n = 0;
        pb_tap = 0; ps_tap = 0; pb_chk = '0; ps_chk = '0; pb_ovf = 1'b0; ps_ovf = 1'b0;
        rst = 1'b1; load = 1'b0; wr = 1'b0; din = '0;
        tick(); tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Known-answer window: three replicated-lane words.
        win.delete();
        win.push_back(rep(16'h0001));
        win.push_back(rep(16'h0002));
        win.push_back(rep(16'hFFFF));
        run_window("kat", 1'b0, 1'b0, 1'b0);
        chk("kat_const_chk", b_chk, 16'h0010);
        chk("kat_const_tap", b_tap, 3);

        fill_random(6);  run_window("ovf6", 1'b0, 1'b1, 1'b0);
        fill_random(1);  run_window("one", 1'b0, 1'b0, 1'b1);
        fill_random(0);  run_window("empty", 1'b0, 1'b0, 1'b1);
        fill_random(3);  run_window("coin", 1'b1, 1'b1, 1'b0);
        fill_random(4);  run_window("coin_full", 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a window, after two accepted words.
        fill_random(5);
        b_done_n = 0; s_done_n = 0;
        load = 1'b1; wr = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            wr = 1'b1; din = win[i];
            tick();
        end
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        load = 1'b0; wr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_no_done", b_done_n + s_done_n, 0);
        chk("midrst_idle", {b_busy, s_busy}, 2'b00);
        pb_tap = 0; ps_tap = 0; pb_chk = '0; ps_chk = '0; pb_ovf = 1'b0; ps_ovf = 1'b0;
        run_window("post_rst", 1'b0, 1'b0, 1'b1);

        fill_random(16); run_window("b2b16", 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            fill_random($urandom_range(0, 10));
            run_window($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        fill_random(WB + 3); run_window("bigovf", 1'b0, 1'b0, 1'b1);
        fill_random(2);      run_window("after_big", 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
